// File: rtl/adder_slice_sequencer_pkg.sv
// rtl/adder_slice_sequencer_pkg.sv - shared types and sizing helpers for the sliced adder sequencer
package adder_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_t;

    // Number of slice passes needed to cover the full operand width.
    function automatic int num_slices(input int adder_width, input int slice_width);
        return (adder_width + slice_width - 1) / slice_width;
    endfunction

    // Slice counter width; a single-slice build still needs one bit.
    function automatic int idx_width(input int n_slices);
        return (n_slices <= 1) ? 1 : $clog2(n_slices);
    endfunction

endpackage

// File: rtl/adder_slice_sequencer_if.sv
// rtl/adder_slice_sequencer_if.sv - start/busy/done operation interface of the sliced adder
interface adder_slice_sequencer_if #(
    parameter int ADDER_WIDTH = 152
);
    logic                   start;
    logic [ADDER_WIDTH-1:0] a;
    logic [ADDER_WIDTH-1:0] b;
    logic                   busy;
    logic                   done;
    logic [ADDER_WIDTH:0]   sum;

    modport master (
        output start, a, b,
        input  busy, done, sum
    );

    modport slave (
        input  start, a, b,
        output busy, done, sum
    );
endinterface

// File: rtl/adder_slice.sv
// rtl/adder_slice.sv - combinational SLICE_WIDTH-bit adder with carry in and carry out
module adder_slice #(
    parameter int SLICE_WIDTH = 32
) (
    input  logic [SLICE_WIDTH-1:0] x,
    input  logic [SLICE_WIDTH-1:0] y,
    input  logic                   cin,
    output logic [SLICE_WIDTH-1:0] s,
    output logic                   cout
);

    // Widen by one bit so the carry-out falls out of the same addition.
    always_comb begin
        {cout, s} = {1'b0, x} + {1'b0, y} + {{SLICE_WIDTH{1'b0}}, cin};
    end

endmodule

// File: rtl/adder_slice_sequencer.sv
// rtl/adder_slice_sequencer.sv - wide unsigned adder built from one shared slice, LS slice first
module adder_slice_sequencer
    import adder_seq_pkg::*;
#(
    parameter int ADDER_WIDTH = 152,
    parameter int SLICE_WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    adder_slice_sequencer_if.slave   bus
);

    localparam int NUM_SLICES = num_slices(ADDER_WIDTH, SLICE_WIDTH);
    localparam int PAD_WIDTH  = NUM_SLICES * SLICE_WIDTH;
    localparam int IDX_WIDTH  = idx_width(NUM_SLICES);
    localparam int SUM_WIDTH  = ADDER_WIDTH + 1;
    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_SLICES - 1);

    seq_state_t             state;
    logic [IDX_WIDTH-1:0]   idx;
    logic                   carry;
    logic [PAD_WIDTH-1:0]   a_sh;
    logic [PAD_WIDTH-1:0]   b_sh;
    logic [PAD_WIDTH-1:0]   res_sh;
    logic [SUM_WIDTH-1:0]   sum_q;
    logic                   busy_q;
    logic                   done_q;

    logic [SLICE_WIDTH-1:0] slice_s;
    logic                   slice_cout;
    logic [PAD_WIDTH-1:0]   res_next;
    logic [PAD_WIDTH:0]     res_full;

    // The one adder resource; always fed from the low slice of the shifting operands.
    adder_slice #(
        .SLICE_WIDTH (SLICE_WIDTH)
    ) u_slice (
        .x    (a_sh[SLICE_WIDTH-1:0]),
        .y    (b_sh[SLICE_WIDTH-1:0]),
        .cin  (carry),
        .s    (slice_s),
        .cout (slice_cout)
    );

    // New slice enters at the top of the result; the final carry sits just above it so a full top
    // slice still gets its carry-out, while a partial one picks it up from the zero padding.
    always_comb begin
        res_next = PAD_WIDTH'({slice_s, res_sh} >> SLICE_WIDTH);
        res_full = {slice_cout, res_next};
    end

    // Sequencer: accept in IDLE, one slice per RUN edge, single-cycle DONE with the result loaded.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            idx    <= '0;
            carry  <= 1'b0;
            a_sh   <= '0;
            b_sh   <= '0;
            res_sh <= '0;
            sum_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_sh   <= PAD_WIDTH'(bus.a);
                        b_sh   <= PAD_WIDTH'(bus.b);
                        idx    <= '0;
                        carry  <= 1'b0;
                        state  <= RUN;
                        busy_q <= 1'b1;
                    end
                end
                RUN: begin
                    carry  <= slice_cout;
                    a_sh   <= a_sh >> SLICE_WIDTH;
                    b_sh   <= b_sh >> SLICE_WIDTH;
                    res_sh <= res_next;
                    if (idx == LAST_IDX) begin
                        idx    <= '0;
                        sum_q  <= SUM_WIDTH'(res_full);
                        state  <= DONE;
                        done_q <= 1'b1;
                    end else begin
                        idx <= idx + IDX_WIDTH'(1);
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.sum  = sum_q;

endmodule
